// File: rtl/byte_serializer_pkg.sv
// Shared PHY definitions: transmit/receive state encoding and the comma/idle fill value.
package byte_serializer_pkg;

   typedef enum logic [1:0] {
      S_RESET  = 2'd0,
      S_TRAIN  = 2'd1,
      S_ACTIVE = 2'd2
   } phy_state_e;

   localparam logic [7:0] IDLE_DEFAULT = 8'hBC;

endpackage

// File: rtl/byte_serializer.sv
// Parallel-to-serial transmit stage: LSB-first bit stream with idle fill, post-reset
// training run and a one-entry holding register behind a valid/ready handshake.
module byte_serializer
   import byte_serializer_pkg::*;
#(
   parameter logic [7:0]  IDLE_BYTE   = IDLE_DEFAULT,
   parameter int unsigned TRAIN_BYTES = 4
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       data_out,
   output logic       valid_out,
   output logic       byte_sync,
   output logic       idle_out
);

   localparam logic [3:0] TRAIN_LAST = 4'(TRAIN_BYTES);

   phy_state_e state_q, state_d;
   logic [7:0] sh_q, sh_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] train_cnt_q, train_cnt_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_v_q, hold_v_d;
   logic       idle_q, idle_d;

   logic load_edge;
   logic active_load;
   logic xfer;

   assign load_edge   = (bit_cnt_q == 3'd7);
   // The last training load already follows the active rule, so data can follow without a gap.
   assign active_load = load_edge &&
                        ((state_q == S_ACTIVE) ||
                         ((state_q == S_TRAIN) && (train_cnt_q == TRAIN_LAST)));
   assign xfer        = valid_in & ready_out;

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q     <= S_RESET;
         sh_q        <= 8'h00;
         bit_cnt_q   <= 3'd0;
         train_cnt_q <= 4'd0;
         hold_q      <= 8'h00;
         hold_v_q    <= 1'b0;
         idle_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         bit_cnt_q   <= bit_cnt_d;
         train_cnt_q <= train_cnt_d;
         hold_q      <= hold_d;
         hold_v_q    <= hold_v_d;
         idle_q      <= idle_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      bit_cnt_d   = bit_cnt_q;
      train_cnt_d = train_cnt_q;
      hold_d      = hold_q;
      hold_v_d    = hold_v_q;
      idle_d      = idle_q;

      unique case (state_q)
         S_RESET: begin
            state_d     = S_TRAIN;
            sh_d        = IDLE_BYTE;
            bit_cnt_d   = 3'd0;
            train_cnt_d = 4'd1;
            idle_d      = 1'b1;
         end
         S_TRAIN, S_ACTIVE: begin
            if (load_edge) begin
               bit_cnt_d = 3'd0;
               if (active_load) begin
                  state_d = S_ACTIVE;
                  if (hold_v_q) begin
                     sh_d     = hold_q;
                     hold_v_d = 1'b0;
                     idle_d   = 1'b0;
                  end else begin
                     sh_d   = IDLE_BYTE;
                     idle_d = 1'b1;
                  end
               end else begin
                  sh_d        = IDLE_BYTE;
                  idle_d      = 1'b1;
                  train_cnt_d = train_cnt_q + 4'd1;
               end
            end else begin
               sh_d      = {1'b0, sh_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
            // A transfer on a load edge refills hold after its old byte moved to sh.
            if (xfer) begin
               hold_d   = data_in;
               hold_v_d = 1'b1;
            end
         end
         default: state_d = S_RESET;
      endcase
   end

   always_comb begin
      valid_out = (state_q == S_TRAIN) || (state_q == S_ACTIVE);
      data_out  = sh_q[0];
      byte_sync = valid_out && (bit_cnt_q == 3'd0);
      idle_out  = idle_q;
      ready_out = (state_q == S_ACTIVE) && (!hold_v_q || load_edge);
   end

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: two instances (4 and 1 training bytes) against a slot-based
// stream model driven by directed phases with random data and random valid timing.
module tb_byte_serializer;

   localparam logic [7:0] IDLE = 8'hBC;

   logic       CLK = 1'b0;
   logic       reset;
   logic [7:0] din   [2];
   logic       vin   [2];
   logic       rdy   [2];
   logic       dout  [2];
   logic       vout  [2];
   logic       bsync [2];
   logic       idl   [2];

   always #5 CLK = ~CLK;

   byte_serializer #(.IDLE_BYTE(IDLE), .TRAIN_BYTES(4)) u_dut_a (
      .CLK       (CLK),
      .reset     (reset),
      .data_in   (din[0]),
      .valid_in  (vin[0]),
      .ready_out (rdy[0]),
      .data_out  (dout[0]),
      .valid_out (vout[0]),
      .byte_sync (bsync[0]),
      .idle_out  (idl[0])
   );

   byte_serializer #(.IDLE_BYTE(IDLE), .TRAIN_BYTES(1)) u_dut_b (
      .CLK       (CLK),
      .reset     (reset),
      .data_in   (din[1]),
      .valid_in  (vin[1]),
      .ready_out (rdy[1]),
      .data_out  (dout[1]),
      .valid_out (vout[1]),
      .byte_sync (bsync[1]),
      .idle_out  (idl[1])
   );

   // Model: run = cycles since reset release (0 while in reset); the stream is a
   // sequence of 8-cycle slots, the first tr slots are idle, later slots take the
   // pending byte if there is one.
   int unsigned tr       [2];
   int unsigned run      [2];
   logic [7:0]  cur      [2];
   bit          cur_idle [2];
   bit          pend_v   [2];
   logic [7:0]  pend     [2];
   bit          offering [2];
   logic [7:0]  off_data [2];
   int unsigned prob;
   logic [7:0]  send_q [$];
   int          n_total;
   int          n_pass;

   function automatic bit exp_ready(input int i);
      if (run[i] <= tr[i] * 8) return 1'b0;
      return !pend_v[i] || (((run[i] - 1) % 8) == 7);
   endfunction

   task automatic check(input string tag, input int i, input logic [7:0] got,
                        input logic [7:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s inst%0d run=%0d: got %0h expected %0h", tag, i, run[i], got, exp);
   endtask

   task automatic do_cycle(input bit rst);
      bit          xfer [2];
      int unsigned pos;
      reset = rst;
      for (int i = 0; i < 2; i++) begin
         if (!offering[i]) begin
            if (i == 0 && send_q.size() > 0) begin
               offering[i] = 1'b1;
               off_data[i] = send_q.pop_front();
            end else if ($urandom_range(99) < prob) begin
               offering[i] = 1'b1;
               off_data[i] = 8'($urandom);
            end
         end
         vin[i]  = offering[i];
         din[i]  = offering[i] ? off_data[i] : 8'($urandom);
         xfer[i] = !rst && offering[i] && exp_ready(i);
      end
      @(posedge CLK);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            run[i]    = 0;
            pend_v[i] = 1'b0;
         end else begin
            run[i]++;
            if (((run[i] - 1) % 8) == 0) begin
               if ((run[i] - 1) / 8 >= tr[i] && pend_v[i]) begin
                  cur[i]      = pend[i];
                  cur_idle[i] = 1'b0;
                  pend_v[i]   = 1'b0;
               end else begin
                  cur[i]      = IDLE;
                  cur_idle[i] = 1'b1;
               end
            end
            if (xfer[i]) begin
               pend[i]     = off_data[i];
               pend_v[i]   = 1'b1;
               offering[i] = 1'b0;
            end
         end
         if (run[i] == 0) begin
            check("data_out",  i, {7'd0, dout[i]},  8'd0);
            check("valid_out", i, {7'd0, vout[i]},  8'd0);
            check("byte_sync", i, {7'd0, bsync[i]}, 8'd0);
            check("idle_out",  i, {7'd0, idl[i]},   8'd0);
            check("ready_out", i, {7'd0, rdy[i]},   8'd0);
         end else begin
            pos = (run[i] - 1) % 8;
            check("data_out",  i, {7'd0, dout[i]},  {7'd0, cur[i][pos]});
            check("valid_out", i, {7'd0, vout[i]},  8'd1);
            check("byte_sync", i, {7'd0, bsync[i]}, {7'd0, pos == 0});
            check("idle_out",  i, {7'd0, idl[i]},   {7'd0, cur_idle[i]});
            check("ready_out", i, {7'd0, rdy[i]},   {7'd0, exp_ready(i)});
         end
      end
   endtask

   initial begin
      bit found;
      tr[0]   = 4;
      tr[1]   = 1;
      n_total = 0;
      n_pass  = 0;
      prob    = 0;
      for (int i = 0; i < 2; i++) begin
         run[i]      = 0;
         cur[i]      = IDLE;
         cur_idle[i] = 1'b1;
         pend_v[i]   = 1'b0;
         pend[i]     = 8'h00;
         offering[i] = 1'b0;
         off_data[i] = 8'h00;
      end

      // Reset, then training with no data; single 0xA5 offered from cycle 20.
      for (int k = 0; k < 3; k++) do_cycle(1'b1);
      for (int k = 0; k < 19; k++) do_cycle(1'b0);
      send_q.push_back(8'hA5);
      for (int k = 0; k < 45; k++) do_cycle(1'b0);

      // Back-to-back directed stream, valid held high.
      send_q.push_back(8'h00);
      send_q.push_back(8'hFF);
      send_q.push_back(8'h3C);
      for (int k = 0; k < 45; k++) do_cycle(1'b0);

      // Saturated random stream keeps hold full with valid held for long stretches.
      prob = 100;
      for (int k = 0; k < 80; k++) do_cycle(1'b0);

      // Sparse random traffic.
      prob = 30;
      for (int k = 0; k < 200; k++) do_cycle(1'b0);

      // Reset in the middle of a data byte (bit 4) with hold full.
      prob  = 100;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (run[0] > tr[0] * 8 && ((run[0] - 1) % 8) == 4 && !cur_idle[0] && pend_v[0])
            found = 1'b1;
         else
            do_cycle(1'b0);
      end
      n_total++;
      assert (found === 1'b1) n_pass++;
      else $error("FAIL midbyte_setup: got %0b expected 1", found);
      do_cycle(1'b1);
      do_cycle(1'b1);
      prob = 0;
      for (int k = 0; k < 60; k++) do_cycle(1'b0);

      // Random traffic again after retraining.
      prob = 60;
      for (int k = 0; k < 80; k++) do_cycle(1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
